pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, hazard stall and flush. Placed between pipeline stages of the segmented ARMv8 core, such as IF/ID, ID/EX, EX/MEM and MEM/WB, and as the PC holding register. It sustains one transfer per cycle. `in_ready` has no combinational path from `out_ready`.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits (≥1).
- `RESET_VAL`, default 0: value loaded into `Q` and internal data registers at reset.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `D`, input, WIDTH: incoming payload.
- `in_valid`, input, 1: upstream presents `D`.
- `in_ready`, output, 1: stage can accept this cycle.
- `Q`, output, WIDTH: outgoing payload (head entry).
- `out_valid`, output, 1: `Q` is valid.
- `out_ready`, input, 1: downstream accepts `Q`.
- `Stall`, input, 1: hazard-unit freeze.
- `Flush`, input, 1: discard all held entries (branch mispredict/exception).
- `stall_cycles`, output, CNT_W: performance counter (see Configuration).
- `xfer_count`, output, CNT_W: performance counter (see Configuration).

## Operation
- Storage: head register `main` drives `Q`; second register `skid` holds overflow.
- States: EMPTY, ONE and FULL. FULL means `main` and `skid` are both valid.
- Combinational handshake signals:
  - `in_ready = (state != FULL) && !Stall`
  - `out_valid = (state != EMPTY) && !Stall`
- Accept: `in_valid && in_ready`.
- Take: `out_valid && out_ready`.
- Transitions when Flush=0:
  - EMPTY, accept → ONE; `main <= D`.
  - ONE, accept and take → ONE; `main <= D`.
  - ONE, accept only → FULL; `skid <= D`.
  - ONE, take only → EMPTY.
  - FULL, take → ONE; `main <= skid`. Accept is impossible in FULL.
  - Any state with no event → hold.
- Stall=1 blocks both accept and take, so state and data are held.
- Flush=1 forces state to EMPTY on the next edge.
  - Flush has priority over Stall and over a same-cycle accept; the accepted `D` is discarded.
  - Upstream sees `in_ready` per the rule above. A flush-cycle accept counts as consumed and is then dropped.
- Data registers are never cleared by Flush. `Q` keeps its last value while EMPTY; only validity changes.
- Ordering is strictly FIFO. No entry is lost or duplicated except by Flush.

## Timing
- Reset asserted (Reset=0) gives, immediately and asynchronously:
  - state EMPTY
  - `Q = RESET_VAL`, `skid = RESET_VAL`
  - `out_valid = 0`, `in_ready = 0` only while Stall=1, otherwise 1
  - counters 0
- Reset deasserts synchronously to `clk` (the external synchroniser is the integrator's responsibility).
- Latency: data accepted at edge N is on `Q` with `out_valid=1` after edge N.
- Throughput: 1 transfer/cycle when `out_ready=1` continuously.
- Backpressure: after `out_ready` drops, one further accept is absorbed into `skid`. `in_ready` is deasserted from the following cycle.
- Reset mid-operation discards all entries. There is no partial transfer.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cycles` increments each cycle where state≠EMPTY and (Stall=1 or `out_ready=0`).
  - `xfer_count` increments on each take.
  - Both counters saturate at all-ones and are not cleared by Flush.
- `PIPE_STAGE_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are synthesised.

## Test plan
- Reset with `RESET_VAL=64'hDEAD`, Reset=0 mid-cycle → `Q=64'hDEAD`, `out_valid=0` without waiting for a clock edge; release → `in_ready=1`.
- Streaming: `D=1,2,3,4` on consecutive cycles, `out_ready=1` → `Q=1,2,3,4` one cycle later each, `xfer_count=4`.
- Backpressure: send 5,6,7 and drop `out_ready` after 5 is taken → 6 on `Q`, 7 held in skid, `in_ready=0`. Raise `out_ready` → 6 then 7 emerge, no loss.
- Stall=1 for 3 cycles while FULL → `out_valid=0`, `in_ready=0`, contents unchanged, `stall_cycles` +3. Release → ordering preserved.
- Flush=1 with Stall=1, state FULL, and `in_valid=1` → next cycle EMPTY, `out_valid=0`, `Q` unchanged, no flushed value ever appears.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer, stall and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             Stall,
  input  logic             Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             take;

  // in_ready depends only on registered state and Stall, never on out_ready
  always_comb begin
    in_ready  = (state != FULL) && !Stall;
    out_valid = (state != EMPTY) && !Stall;
    accept    = in_valid && in_ready;
    take      = out_valid && out_ready;
  end

  assign Q = main_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= EMPTY;
    end else if (Flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !take)      state <= FULL;
          else if (!accept && take) state <= EMPTY;
        end
        FULL:    if (take) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Data registers are left untouched by Flush; only validity is dropped
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (!Flush) begin
      case (state)
        EMPTY: if (accept) main_q <= D;
        ONE: begin
          if (accept && take) main_q <= D;
          else if (accept)    skid_q <= D;
        end
        FULL:    if (take) main_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] xfer_cnt;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if ((state != EMPTY) && (Stall || !out_ready) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (take && (xfer_cnt != '1))
        xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
  assign xfer_count   = xfer_cnt;
`else
  assign stall_cycles = '0;
  assign xfer_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the stage.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        Reset;
  logic [63:0] D;
  logic        in_valid, in_ready, out_valid, out_ready, Stall, Flush;
  logic [63:0] Q;
  logic [31:0] stall_cycles, xfer_count;

  int tests = 0;
  int fails = 0;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(64), .RESET_VAL(64'hDEAD), .CNT_W(32)) dut (
    .clk(clk), .Reset(Reset), .D(D), .in_valid(in_valid), .in_ready(in_ready),
    .Q(Q), .out_valid(out_valid), .out_ready(out_ready), .Stall(Stall), .Flush(Flush),
    .stall_cycles(stall_cycles), .xfer_count(xfer_count)
  );

  // Reference model: a FIFO of at most two entries, plus the last head value seen on Q
  logic [63:0] mq[$];
  logic [63:0] mhead;
  int unsigned m_sc, m_xf;

  function automatic void model_reset();
    mq.delete();
    mhead = 64'hDEAD;
    m_sc  = 0;
    m_xf  = 0;
  endfunction

  function automatic logic exp_in_ready();
    return (mq.size() < 2) && !Stall;
  endfunction

  function automatic logic exp_out_valid();
    return (mq.size() > 0) && !Stall;
  endfunction

  function automatic logic [31:0] exp_sc();
    return PERF ? m_sc : 32'd0;
  endfunction

  function automatic logic [31:0] exp_xf();
    return PERF ? m_xf : 32'd0;
  endfunction

  function automatic void model_edge();
    bit acc, tk;
    acc = in_valid && exp_in_ready();
    tk  = exp_out_valid() && out_ready;
    if ((mq.size() > 0) && (Stall || !out_ready)) m_sc++;
    if (tk) m_xf++;
    if (Flush) mq.delete();
    else begin
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back(D);
    end
    if (mq.size() > 0) mhead = mq[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic iv, input logic ordy,
                       input logic st, input logic fl);
    D = d; in_valid = iv; out_ready = ordy; Stall = st; Flush = fl;
    #1;
  endtask

  task automatic test_reset();
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3 Reset = 1'b0;
    model_reset();
    #1;
    tests++; if (Q !== 64'hDEAD) begin fails++; $display("FAIL reset_q: got %h exp %h", Q, 64'hDEAD); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    Stall = 1'b1; #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_stall: got %b exp 0", in_ready); end
    Stall = 1'b0;
    tests++; if (stall_cycles !== 32'd0 || xfer_count !== 32'd0) begin
      fails++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", stall_cycles, xfer_count); end
    @(posedge clk); #2 Reset = 1'b1;
    tick();
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL release: got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 4; k++) begin
      drive(64'(k), 1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %b exp 1", k, in_ready); end
      tick();
      tests++; if (Q !== 64'(k) || out_valid !== 1'b1) begin
        fails++; $display("FAIL stream_q[%0d]: got %h/%b exp %h/1", k, Q, out_valid, 64'(k)); end
    end
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0 || Q !== 64'd4) begin
      fails++; $display("FAIL stream_drain: got %h/%b exp 4/0", Q, out_valid); end
    tests++; if (xfer_count !== (PERF ? 32'd4 : 32'd0)) begin
      fails++; $display("FAIL stream_xfer: got %0d exp %0d", xfer_count, PERF ? 4 : 0); end
  endtask

  task automatic test_backpressure();
    drive(64'd5, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(64'd6, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(64'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_absorb: got in_ready=%b exp 1", in_ready); end
    tick();
    drive(64'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (in_ready !== 1'b0 || Q !== 64'd6 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_full: got in_ready=%b Q=%h ov=%b exp 0/6/1", in_ready, Q, out_valid); end
    tick();
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (Q !== 64'd6) begin fails++; $display("FAIL bp_first: got %h exp 6", Q); end
    tick();
    tests++; if (Q !== 64'd7 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_second: got %h/%b exp 7/1", Q, out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0 || Q !== 64'd7) begin
      fails++; $display("FAIL bp_empty: got %h/%b exp 7/0", Q, out_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] sc0;
    drive(64'd9, 1'b1, 1'b0, 1'b0, 1'b0);  tick();
    drive(64'd10, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    sc0 = stall_cycles;
    for (int i = 0; i < 3; i++) begin
      drive(64'd11, 1'b1, 1'b1, 1'b1, 1'b0);
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || Q !== 64'd9) begin
        fails++; $display("FAIL stall_hold[%0d]: got ov=%b ir=%b Q=%h exp 0/0/9", i, out_valid, in_ready, Q); end
      tick();
    end
    tests++; if (stall_cycles - sc0 !== (PERF ? 32'd3 : 32'd0)) begin
      fails++; $display("FAIL stall_count: got +%0d exp +%0d", stall_cycles - sc0, PERF ? 3 : 0); end
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (Q !== 64'd9 || out_valid !== 1'b1) begin
      fails++; $display("FAIL stall_release0: got %h/%b exp 9/1", Q, out_valid); end
    tick();
    tests++; if (Q !== 64'd10 || out_valid !== 1'b1) begin
      fails++; $display("FAIL stall_release1: got %h/%b exp 10/1", Q, out_valid); end
    tick();
  endtask

  task automatic test_flush();
    drive(64'd11, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(64'd12, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(64'd13, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      tests++; if (out_valid !== 1'b0 || Q !== 64'd11 || in_ready !== 1'b1) begin
        fails++; $display("FAIL flush_full[%0d]: got ov=%b Q=%h ir=%b exp 0/11/1", i, out_valid, Q, in_ready); end
      tick();
    end
    drive(64'd14, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(64'd15, 1'b1, 1'b1, 1'b0, 1'b1);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_accept_ready: got %b exp 1", in_ready); end
    tick();
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0 || Q !== 64'd14) begin
      fails++; $display("FAIL flush_one: got %h/%b exp 14/0", Q, out_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive({$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
      tests++;
      if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid() || Q !== mhead ||
          stall_cycles !== exp_sc() || xfer_count !== exp_xf()) begin
        fails++;
        $display("FAIL random[%0d]: got ir=%b ov=%b Q=%h sc=%0d xf=%0d exp %b/%b/%h/%0d/%0d", n,
                 in_ready, out_valid, Q, stall_cycles, xfer_count,
                 exp_in_ready(), exp_out_valid(), mhead, exp_sc(), exp_xf());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(64'd21, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(64'd22, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 Reset = 1'b0;
    model_reset();
    #1;
    tests++; if (Q !== 64'hDEAD || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid: got Q=%h ov=%b ir=%b exp dead/0/1", Q, out_valid, in_ready); end
    tests++; if (stall_cycles !== 32'd0 || xfer_count !== 32'd0) begin
      fails++; $display("FAIL reset_mid_counters: got %0d/%0d exp 0/0", stall_cycles, xfer_count); end
    @(posedge clk); #2 Reset = 1'b1;
    drive(64'd23, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (Q !== 64'd23 || out_valid !== 1'b1) begin
      fails++; $display("FAIL reset_mid_resume: got %h/%b exp 23/1", Q, out_valid); end
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
